// File: rtl/pia_pkg.sv
// Purpose: shared constants and types for the Apple-1 PIA replacement (register map, TX states).
// Latency: n/a (package only).
// Backpressure: n/a.
package pia_pkg;

  // Register offsets within the $D010-$D013 window (addr[1:0]).
  localparam logic [1:0]  PIA_KBD   = 2'd0;
  localparam logic [1:0]  PIA_KBDCR = 2'd1;
  localparam logic [1:0]  PIA_DSP   = 2'd2;
  localparam logic [1:0]  PIA_DSPCR = 2'd3;

  // Decoder base address of the register window.
  localparam logic [15:0] PIA_BASE  = 16'hD010;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_PEND = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

  // Map 'a'..'z' to 'A'..'Z' when enabled; the full byte is compared so
  // 8'hE1 is not treated as lowercase. Returns the 7-bit stored value.
  function automatic logic [6:0] rx_map(input logic [7:0] b, input bit upcase);
    logic [6:0] r;
    r = b[6:0];
    if (upcase && (b >= 8'h61) && (b <= 8'h7A)) r[5] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: generic single-clock FIFO with show-ahead dout.
// Latency: push visible on dout/count the clk after the push edge; pop advances on the edge.
// Backpressure: push while full and pop while empty are ignored; caller watches full/empty.
//
// Ports:
//   clk, res       clock and synchronous active-low reset (clears pointers and count)
//   push, din      write request and data
//   pop            read request; dout always shows the head entry
//   full, empty    occupancy flags
//   count          occupancy, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pia_uart_bridge.sv
// Purpose: Apple-1 PIA replacement; Wozmon KBD/KBDCR/DSP/DSPCR registers over a uart with RX FIFO.
// Latency: reads registered into dbi on the bus edge; tx_start 1 clk after a DSP write if uart idle.
// Backpressure: RX throttled by cts (registered occupancy threshold); full FIFO drops and sets rx_overrun.
//
// Ports:
//   clk, res                 clock; synchronous active-low reset
//   phi_en, cs, addr, rw     CPU bus strobe, select, register offset, direction
//   dbo / dbi                CPU write data / registered read data
//   rx_received, rx_byte     uart receive pulse and byte
//   tx_busy                  uart transmitter busy
//   tx_start, tx_byte        one-clk transmit pulse and 7-bit ASCII byte
//   cts, rx_overrun          host pause request; sticky RX drop flag
module pia_uart_bridge
  import pia_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int CTS_MARGIN = 4,
  parameter bit UPCASE     = 1'b1
) (
  input  logic       clk,
  input  logic       res,
  input  logic       phi_en,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       rw,
  input  logic [7:0] dbo,
  output logic [7:0] dbi,
  input  logic       rx_received,
  input  logic [7:0] rx_byte,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       cts,
  output logic       rx_overrun
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CTS_LEVEL_I = DEPTH - CTS_MARGIN;
  localparam logic [CNT_W-1:0] CTS_LEVEL = CTS_LEVEL_I[CNT_W-1:0];

  logic             bus_acc;
  logic             bus_rd;
  logic             rd_kbd;
  logic             rd_kbdcr;
  logic             wr_dsp;
  logic             fifo_push;
  logic             fifo_pop;
  logic             overrun_evt;
  logic [6:0]       fifo_din;
  logic [6:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  tx_state_t        tx_state;
  logic             tx_pending;
  logic             wait_cnt;

  // dbo[7] is forced to 0 on TX; rx_byte[7] only matters to the upcase compare.
  logic             unused_bits;
  assign unused_bits = ^{dbo[7], rx_byte[7]};

  assign bus_acc  = phi_en & cs;
  assign bus_rd   = bus_acc & rw;
  assign rd_kbd   = bus_rd & (addr == PIA_KBD);
  assign rd_kbdcr = bus_rd & (addr == PIA_KBDCR);
  assign wr_dsp   = bus_acc & ~rw & (addr == PIA_DSP);

  // Pop only when something is there, so an empty-FIFO KBD read returns 00
  // while a same-edge push still lands.
  assign fifo_pop    = rd_kbd & ~fifo_empty;
  assign fifo_push   = rx_received & ~fifo_full;
  assign overrun_evt = rx_received & fifo_full;
  assign fifo_din    = rx_map(rx_byte, UPCASE);

  sync_fifo #(
    .WIDTH (7),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register read path, overrun flag and cts.
  always_ff @(posedge clk) begin
    if (!res) begin
      dbi        <= 8'h00;
      rx_overrun <= 1'b0;
      cts        <= 1'b0;
    end else begin
      if (bus_rd) begin
        case (addr)
          PIA_KBD:   dbi <= fifo_empty ? 8'h00 : {1'b1, fifo_dout};
          PIA_KBDCR: dbi <= {~fifo_empty, 6'b0, rx_overrun};
          PIA_DSP:   dbi <= {tx_pending | tx_busy, 7'b0};
          default:   dbi <= 8'h00;
        endcase
      end
      // A drop on the same edge as the clearing read keeps the flag set.
      if (overrun_evt)   rx_overrun <= 1'b1;
      else if (rd_kbdcr) rx_overrun <= 1'b0;
      cts <= (fifo_count >= CTS_LEVEL);
    end
  end

  // TX sequencer. WAIT gives the uart up to two clks to raise tx_busy so the
  // CPU never sees DSP ready in the gap between tx_start and busy.
  always_ff @(posedge clk) begin
    if (!res) begin
      tx_state   <= TX_IDLE;
      tx_pending <= 1'b0;
      tx_start   <= 1'b0;
      tx_byte    <= 8'h00;
      wait_cnt   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (wr_dsp && !tx_pending) begin
            tx_byte    <= {1'b0, dbo[6:0]};
            tx_pending <= 1'b1;
            tx_state   <= TX_PEND;
          end
        end
        TX_PEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            wait_cnt <= 1'b0;
            tx_state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tx_busy || wait_cnt) begin
            tx_pending <= 1'b0;
            tx_state   <= TX_IDLE;
          end else begin
            wait_cnt <= 1'b1;
          end
        end
        default: begin
          tx_pending <= 1'b0;
          tx_state   <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
